// File: rtl/excpt_pkg.sv
// Shared definitions for the exception/interrupt controller.
//   - exception code constants seen on excptype / recorded in cause_q[7:0]
//   - FSM state encodings
//   - bit positions of the fields inside status_q = {im, exl, ie}
package excpt_pkg;

  localparam logic [7:0] EXC_SYSCALL = 8'h08;
  localparam logic [7:0] EXC_ERET    = 8'h0e;
  localparam logic [7:0] EXC_INT     = 8'h01;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  typedef enum logic [0:0] {
    IDLE  = ST_IDLE,
    FLUSH = ST_FLUSH
  } state_e;

  localparam int unsigned STAT_IE     = 0;
  localparam int unsigned STAT_EXL    = 1;
  localparam int unsigned STAT_IM_LSB = 2;

endpackage

// File: rtl/excpt_ctrl_irq_sync.sv
// Two-flop synchronizer for the asynchronous external interrupt levels.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   i_irq      raw asynchronous interrupt levels
//   o_pend     synchronized levels (two clocks of latency)
module irq_sync #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_irq,
  output logic [WIDTH-1:0] o_pend
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_irq;
      r_s2 <= r_s1;
    end
  end

  assign o_pend = r_s2;

endmodule

// File: rtl/excpt_ctrl.sv
// Exception and interrupt controller sitting beside the MEM stage.
// Arbitrates a synchronous exception code against masked, synchronized
// interrupts, keeps CP0-style EPC/cause/status state, and issues a
// registered redirect (ejpc/excpt) plus a FLUSH_CYCLES-long pipeline flush.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   excptype, epc     exception code (0 = none) and PC of the MEM instruction
//   irq               asynchronous level interrupt requests
//   csr_we, csr_wdata status write strobe and {im, ie}
//   ejpc, excpt       redirect target and its one-cycle valid pulse
//   excpt_l           duplicate of excpt for the fetch load path
//   flush             pipeline flush
//   epc_q, cause_q    saved PC and {irq snapshot, code}
//   status_q          {im, exl, ie}
module excpt_ctrl
  import excpt_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     NUM_IRQ      = 6,
  parameter logic [XLEN-1:0] VEC_SYSCALL  = 32'h0000_0040,
  parameter logic [XLEN-1:0] VEC_IRQ      = 32'h0000_0050,
  parameter int unsigned     FLUSH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [XLEN-1:0]      excptype,
  input  logic [XLEN-1:0]      epc,
  input  logic [NUM_IRQ-1:0]   irq,
  input  logic                 csr_we,
  input  logic [NUM_IRQ:0]     csr_wdata,
  output logic [XLEN-1:0]      ejpc,
  output logic                 excpt,
  output logic                 excpt_l,
  output logic                 flush,
  output logic [XLEN-1:0]      epc_q,
  output logic [XLEN-1:0]      cause_q,
  output logic [NUM_IRQ+1:0]   status_q
);

  // The FLUSH state covers all but the last flush cycle, so the controller is
  // already back in IDLE during the final flush cycle and can accept the next
  // event on the edge that ends it.
  localparam int unsigned CW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES - 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((FLUSH_CYCLES >= 2) ? FLUSH_CYCLES - 2 : 0);

  logic [NUM_IRQ-1:0] w_pend;

  irq_sync #(.WIDTH(NUM_IRQ)) u_irq_sync (
    .clk    (clk),
    .rst    (rst),
    .i_irq  (irq),
    .o_pend (w_pend)
  );

  state_e              r_state;
  logic [CW-1:0]       r_cnt;
  logic [XLEN-1:0]     r_ejpc;
  logic                r_excpt;
  logic                r_excpt_l;
  logic                r_flush;
  logic [XLEN-1:0]     r_epc;
  logic [XLEN-1:0]     r_cause;
  logic [NUM_IRQ-1:0]  r_im;
  logic                r_exl;
  logic                r_ie;

  logic                w_exc;
  logic                w_eret;
  logic                w_irq_ok;
  logic                w_take;
  logic [7:0]          w_code;
  logic [XLEN-1:0]     w_target;
  logic [XLEN-1:0]     w_cause;

  assign w_exc    = |excptype;
  assign w_eret   = (excptype == {{(XLEN-8){1'b0}}, EXC_ERET});
  assign w_irq_ok = (|(w_pend & r_im)) & r_ie & ~r_exl;
  // Synchronous codes win over interrupts; nothing is taken outside IDLE.
  assign w_take   = (r_state == IDLE) & (w_exc | w_irq_ok);
  assign w_code   = w_exc ? excptype[7:0] : EXC_INT;

  always_comb begin
    w_target = VEC_SYSCALL;
    if (w_eret) begin
      w_target = r_epc;
    end else if (w_code == EXC_INT) begin
      w_target = VEC_IRQ;
    end
  end

  always_comb begin
    w_cause              = '0;
    w_cause[7:0]         = w_code;
    w_cause[NUM_IRQ+7:8] = w_pend;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_ejpc    <= '0;
      r_excpt   <= 1'b0;
      r_excpt_l <= 1'b0;
      r_flush   <= 1'b0;
      r_epc     <= '0;
      r_cause   <= '0;
      r_im      <= '0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
    end else begin
      r_excpt   <= w_take;
      r_excpt_l <= w_take;
      r_flush   <= w_take | (r_state == FLUSH);

      if (w_take) begin
        r_ejpc <= w_target;
      end

      if (csr_we) begin
        r_im <= csr_wdata[NUM_IRQ:1];
        r_ie <= csr_wdata[0];
      end

      if (w_take) begin
        if (w_eret) begin
          r_exl <= 1'b0;
        end else begin
          r_cause <= w_cause;
          r_exl   <= 1'b1;
          // A nested exception keeps the original return address.
          if (!r_exl) begin
            r_epc <= epc;
          end
        end
      end

      if (r_state == IDLE) begin
        if (w_take && (FLUSH_CYCLES > 1)) begin
          r_state <= FLUSH;
          r_cnt   <= CNT_INIT;
        end
      end else begin
        if (r_cnt == '0) begin
          r_state <= IDLE;
        end else begin
          r_cnt <= r_cnt - CW'(1);
        end
      end
    end
  end

  assign ejpc     = r_ejpc;
  assign excpt    = r_excpt;
  assign excpt_l  = r_excpt_l;
  assign flush    = r_flush;
  assign epc_q    = r_epc;
  assign cause_q  = r_cause;
  assign status_q = {r_im, r_exl, r_ie};

endmodule

// File: tb/tb_excpt_ctrl.sv
// Directed testbench for excpt_ctrl with hand-computed expected values.
module tb_excpt_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] excptype;
  logic [31:0] epc;
  logic [5:0]  irq;
  logic        csr_we;
  logic [6:0]  csr_wdata;
  logic [31:0] ejpc;
  logic        excpt;
  logic        excpt_l;
  logic        flush;
  logic [31:0] epc_q;
  logic [31:0] cause_q;
  logic [7:0]  status_q;

  int unsigned n_chk;
  int unsigned n_err;
  int unsigned n_pulse;

  excpt_ctrl #(
    .XLEN         (32),
    .NUM_IRQ      (6),
    .VEC_SYSCALL  (32'h0000_0040),
    .VEC_IRQ      (32'h0000_0050),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .excptype  (excptype),
    .epc       (epc),
    .irq       (irq),
    .csr_we    (csr_we),
    .csr_wdata (csr_wdata),
    .ejpc      (ejpc),
    .excpt     (excpt),
    .excpt_l   (excpt_l),
    .flush     (flush),
    .epc_q     (epc_q),
    .cause_q   (cause_q),
    .status_q  (status_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk     = 0;
    n_err     = 0;
    rst       = 1'b1;
    excptype  = '0;
    epc       = '0;
    irq       = '0;
    csr_we    = 1'b0;
    csr_wdata = '0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_ejpc",   ejpc,     32'h0);
    chk("rst_excpt",  excpt,    1'b0);
    chk("rst_excptl", excpt_l,  1'b0);
    chk("rst_flush",  flush,    1'b0);
    chk("rst_epcq",   epc_q,    32'h0);
    chk("rst_cause",  cause_q,  32'h0);
    chk("rst_status", status_q, 8'h00);

    // Syscall with exl=0.
    excptype = 32'h08;
    epc      = 32'h0000_1234;
    tick();
    chk("sys_excpt",  excpt,    1'b1);
    chk("sys_excptl", excpt_l,  1'b1);
    chk("sys_ejpc",   ejpc,     32'h40);
    chk("sys_flush1", flush,    1'b1);
    chk("sys_epcq",   epc_q,    32'h1234);
    chk("sys_cause",  cause_q,  32'h08);
    chk("sys_status", status_q, 8'h02);
    // Syscall presented during the excpt cycle must be ignored.
    epc = 32'h0000_2000;
    tick();
    excptype = '0;
    chk("ign_excpt",  excpt,    1'b0);
    chk("sys_flush2", flush,    1'b1);
    chk("ign_epcq",   epc_q,    32'h1234);
    tick();
    chk("sys_flush3", flush,    1'b0);
    chk("ign_excpt2", excpt,    1'b0);

    // eret back to saved PC.
    excptype = 32'h0e;
    tick();
    excptype = '0;
    chk("eret_excpt",  excpt,    1'b1);
    chk("eret_ejpc",   ejpc,     32'h1234);
    chk("eret_status", status_q, 8'h00);
    chk("eret_cause",  cause_q,  32'h08);
    tick();
    tick();
    chk("eret_flush_end", flush, 1'b0);

    // Enable irq[0] and raise it: excpt appears on the third edge.
    csr_we    = 1'b1;
    csr_wdata = 7'b0000011;
    tick();
    csr_we = 1'b0;
    chk("csr_status", status_q, 8'h05);
    epc = 32'h0000_3000;
    irq = 6'b000001;
    tick();
    chk("irq_lat1", excpt, 1'b0);
    tick();
    chk("irq_lat2", excpt, 1'b0);
    tick();
    chk("irq_excpt",  excpt,    1'b1);
    chk("irq_ejpc",   ejpc,     32'h50);
    chk("irq_cause",  cause_q,  32'h101);
    chk("irq_epcq",   epc_q,    32'h3000);
    chk("irq_status", status_q, 8'h07);
    n_pulse = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (excpt) n_pulse++;
    end
    chk("irq_held_exl", n_pulse, 0);

    // eret, then syscall and eligible irq together: syscall wins.
    excptype = 32'h0e;
    tick();
    excptype = '0;
    chk("eret2_ejpc", ejpc, 32'h3000);
    tick();
    excptype = 32'h08;
    epc      = 32'h0000_4000;
    tick();
    excptype = '0;
    chk("pri_excpt", excpt,   1'b1);
    chk("pri_ejpc",  ejpc,    32'h40);
    chk("pri_cause", cause_q, 32'h108);
    chk("pri_epcq",  epc_q,   32'h4000);
    tick();
    chk("pri_noirq", excpt, 1'b0);
    excptype = 32'h0e;
    tick();
    excptype = '0;
    epc      = 32'h0000_5000;
    chk("eret3_ejpc", ejpc, 32'h4000);
    tick();
    tick();
    chk("irq2_excpt", excpt,   1'b1);
    chk("irq2_ejpc",  ejpc,    32'h50);
    chk("irq2_epcq",  epc_q,   32'h5000);
    chk("irq2_cause", cause_q, 32'h101);

    // Drop the request and leave the handler.
    irq = '0;
    tick();
    excptype = 32'h0e;
    tick();
    excptype = '0;
    chk("eret4_ejpc", ejpc, 32'h5000);
    tick();
    tick();
    chk("eret4_status", status_q, 8'h05);

    // Unknown code, then reset in the middle of the flush.
    excptype = 32'h1f;
    epc      = 32'h0000_6000;
    tick();
    excptype = '0;
    chk("unk_excpt", excpt,   1'b1);
    chk("unk_ejpc",  ejpc,    32'h40);
    chk("unk_cause", cause_q, 32'h1f);
    chk("unk_epcq",  epc_q,   32'h6000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_ejpc",   ejpc,     32'h0);
    chk("mrst_excpt",  excpt,    1'b0);
    chk("mrst_excptl", excpt_l,  1'b0);
    chk("mrst_flush",  flush,    1'b0);
    chk("mrst_epcq",   epc_q,    32'h0);
    chk("mrst_cause",  cause_q,  32'h0);
    chk("mrst_status", status_q, 8'h00);

    // FSM is idle right after reset; csr write lands with the event.
    excptype  = 32'h08;
    epc       = 32'h0000_7000;
    csr_we    = 1'b1;
    csr_wdata = 7'b1111110;
    tick();
    excptype = '0;
    csr_we   = 1'b0;
    chk("post_excpt",  excpt,    1'b1);
    chk("post_ejpc",   ejpc,     32'h40);
    chk("post_epcq",   epc_q,    32'h7000);
    chk("post_status", status_q, 8'hfe);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/excpt_ctrl.md
# excpt_ctrl

Parametrised exception and interrupt controller for the five-stage core. It sits beside the MEM stage and accepts the encoded exception type and faulting PC from the pipeline, plus external interrupt lines. It arbitrates synchronous exceptions against masked interrupts and keeps EPC/cause/status state. On a taken event it emits a registered redirect target and a multi-cycle pipeline flush, replacing the former purely combinational exception decoder.

## Interface
Parameters:
- XLEN, 32, datapath / PC width
- NUM_IRQ, 6, external interrupt lines
- VEC_SYSCALL, 32'h0000_0040, syscall / general exception vector
- VEC_IRQ, 32'h0000_0050, interrupt vector
- FLUSH_CYCLES, 2, cycles `flush` stays high per event (>=1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- excptype  in  XLEN  exception code from MEM stage; 0 = none
- epc  in  XLEN  PC of the instruction in MEM
- irq  in  NUM_IRQ  asynchronous level interrupt requests
- csr_we  in  1  status write strobe
- csr_wdata  in  NUM_IRQ+1  {im[NUM_IRQ-1:0], ie}
- ejpc  out  XLEN  redirect target, valid while `excpt`=1
- excpt  out  1  one-cycle redirect pulse
- excpt_l  out  1  copy of `excpt` for the fetch-stage load path
- flush  out  1  pipeline flush, FLUSH_CYCLES long
- epc_q  out  XLEN  saved exception PC
- cause_q  out  XLEN  saved code, irq snapshot in [NUM_IRQ+7:8]
- status_q  out  NUM_IRQ+2  {im, exl, ie}

## Operation
- Codes: 0x08 syscall -> VEC_SYSCALL; 0x0e eret -> epc_q; 0x01 software interrupt -> VEC_IRQ. Any other nonzero code goes to VEC_SYSCALL, with the code recorded as given.
- irq passes through a 2-flop synchronizer to form `pend`. Levels are not latched; the device holds its request until serviced.
- An interrupt is eligible when `pend & im` != 0, ie=1, and exl=0.
- Priority, evaluated in IDLE only: nonzero excptype, then eligible interrupt.
- FSM IDLE -> FLUSH on a taken event. FLUSH counts FLUSH_CYCLES-1 further cycles, then returns to IDLE.
- In FLUSH, excptype, interrupts and eret are ignored. csr writes are still accepted.
- Exception or interrupt taken:
  - when exl=0: epc_q <= epc, cause_q <= {pend snapshot, code}, exl <= 1.
  - when exl=1 (nested synchronous exception): epc_q is kept; cause_q is updated; target is the vector.
- Interrupt taken: code 0x01, ejpc = VEC_IRQ.
- eret: ejpc = current epc_q, exl <= 0, cause unchanged. eret with exl=0 still redirects to epc_q.
- csr_we in the same cycle as a taken event: im/ie take csr_wdata, and exl follows the event.

## Timing
- Reset: ejpc=0, excpt=0, excpt_l=0, flush=0, epc_q=0, cause_q=0, status_q: im=0, exl=0, ie=0; FSM=IDLE; synchronizer flops=0.
- excptype/epc sampled at edge N. excpt, ejpc, flush and the state updates are all visible after edge N (cycle N+1). Latency is 1 cycle.
- excpt is high exactly one cycle. flush is high FLUSH_CYCLES cycles starting the same cycle.
- The earliest next accepted event is sampled at the edge ending the last flush cycle.
- irq rising to excpt high: 3 cycles (2 sync + 1), given enabled and IDLE.
- ejpc holds its last value when excpt=0; it is never a latch.
- rst during FLUSH: outputs drop to reset values at the next edge, and the FSM goes to IDLE.

## Structure
- Package excpt_pkg:
  - code constants EXC_SYSCALL=0x08, EXC_ERET=0x0e, EXC_INT=0x01
  - FSM state enum {IDLE, FLUSH}
  - status field bit positions
- Sub-module irq_sync: NUM_IRQ-wide 2-flop synchronizer with synchronous reset.
- Control logic and CP0-style registers live in excpt_ctrl.

## Test plan
- excptype=0x08, epc=0x0000_1234, exl=0 -> next cycle excpt=1, ejpc=0x40, flush for 2 cycles, epc_q=0x1234, cause_q[7:0]=0x08, exl=1.
- After the above, excptype=0x0e -> excpt=1, ejpc=0x1234, exl=0.
- csr_wdata: im=6'b000001, ie=1; irq[0] raised -> excpt 3 cycles later, ejpc=0x50, cause_q[8]=1. Then irq[0] held high with exl=1 -> no second event.
- Simultaneous excptype=0x08 and eligible irq -> syscall taken (ejpc=0x40); interrupt taken after eret clears exl.
- excptype=0x08 asserted on the cycle after excpt -> ignored, no second excpt pulse.
- Unknown code 0x1f -> ejpc=0x40, cause_q[7:0]=0x1f; rst asserted mid-FLUSH -> all outputs zero the next cycle.
